cpu_cu: RTL and testbench

Control unit for the 16-bit CPU: a multi-cycle fetch/decode/execute state machine that sits directly upstream of the execution unit and drives every one of its control inputs. It reads the instruction register contents and the ALU flags, and generates the memory read and write strobes. It also holds the architectural status register (N, Z, C) used for conditional branches.

---
 rtl/cpu_cu_pkg.sv | 34 +++
 rtl/cpu_cond_eval.sv | 25 ++
 rtl/cpu_cu.sv | 110 +++++++++++
 tb/tb_cpu_cu.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_cu_pkg.sv
// rtl/cpu_cu_pkg.sv - state, opcode and condition-code constants for the cpu control unit
package cpu_cu_pkg;

  typedef enum logic [2:0] {
    FETCH    = 3'd0,
    DECODE   = 3'd1,
    EXEC_ALU = 3'd2,
    LOAD     = 3'd3,
    STORE    = 3'd4,
    BRANCH   = 3'd5,
    HALT     = 3'd6
  } state_t;

  localparam logic [3:0] OP_ALU_MAX = 4'hB;
  localparam logic [3:0] OP_LOAD    = 4'hC;
  localparam logic [3:0] OP_STORE   = 4'hD;
  localparam logic [3:0] OP_BR      = 4'hE;
  localparam logic [3:0] OP_HALT    = 4'hF;

  localparam logic [2:0] CC_AL = 3'b000;
  localparam logic [2:0] CC_Z  = 3'b001;
  localparam logic [2:0] CC_NZ = 3'b010;
  localparam logic [2:0] CC_N  = 3'b011;
  localparam logic [2:0] CC_NN = 3'b100;
  localparam logic [2:0] CC_C  = 3'b101;
  localparam logic [2:0] CC_NC = 3'b110;
  localparam logic [2:0] CC_NV = 3'b111;

  // bit positions inside the {N,Z,C} status word
  localparam int ST_N = 2;
  localparam int ST_Z = 1;
  localparam int ST_C = 0;

endpackage

// File: rtl/cpu_cond_eval.sv
// rtl/cpu_cond_eval.sv - combinational branch-condition check against registered {N,Z,C}
module cpu_cond_eval
  import cpu_cu_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] status,
  output logic       take
);

  always_comb begin
    take = 1'b0;
    case (cond)
      CC_AL:   take = 1'b1;
      CC_Z:    take = status[ST_Z];
      CC_NZ:   take = !status[ST_Z];
      CC_N:    take = status[ST_N];
      CC_NN:   take = !status[ST_N];
      CC_C:    take = status[ST_C];
      CC_NC:   take = !status[ST_C];
      CC_NV:   take = 1'b0;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_cu.sv
// rtl/cpu_cu.sv - multi-cycle fetch/decode/execute control unit with {N,Z,C} status register
module cpu_cu
  import cpu_cu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir,
  input  logic        n_in,
  input  logic        z_in,
  input  logic        c_in,
  output logic        adr_sel,
  output logic        s_sel,
  output logic        pc_ld,
  output logic        pc_inc,
  output logic        reg_w_en,
  output logic        ir_ld,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [2:0]  status,
  output logic [2:0]  state,
  output logic        halted
);

  localparam state_t RESET_STATE = FETCH;

  state_t     state_q;
  state_t     state_d;
  logic [2:0] status_q;
  logic       take;
  logic [3:0] opcode;

  assign opcode = ir[15:12];

  cpu_cond_eval u_cond_eval (
    .cond   (ir[11:9]),
    .status (status_q),
    .take   (take)
  );

  // Reset lands in FETCH, so write strobes fall combinationally as soon as reset asserts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RESET_STATE;
      status_q <= 3'b000;
    end else begin
      state_q <= state_d;
      if (state_q == EXEC_ALU) begin
        status_q <= {n_in, z_in, c_in};
      end
    end
  end

  always_comb begin
    state_d  = FETCH;
    adr_sel  = 1'b0;
    s_sel    = 1'b0;
    pc_ld    = 1'b0;
    pc_inc   = 1'b0;
    reg_w_en = 1'b0;
    ir_ld    = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    case (state_q)
      FETCH: begin
        mem_rd  = 1'b1;
        ir_ld   = 1'b1;
        pc_inc  = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        if (opcode <= OP_ALU_MAX)     state_d = EXEC_ALU;
        else if (opcode == OP_LOAD)   state_d = LOAD;
        else if (opcode == OP_STORE)  state_d = STORE;
        else if (opcode == OP_BR)     state_d = BRANCH;
        else                          state_d = HALT;
      end
      EXEC_ALU: begin
        reg_w_en = 1'b1;
        state_d  = FETCH;
      end
      LOAD: begin
        mem_rd   = 1'b1;
        adr_sel  = 1'b1;
        s_sel    = 1'b1;
        reg_w_en = 1'b1;
        state_d  = FETCH;
      end
      STORE: begin
        mem_wr  = 1'b1;
        adr_sel = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        pc_ld   = take;
        state_d = FETCH;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign status = status_q;
  assign state  = state_q;
  assign halted = (state_q == HALT);

endmodule

// File: tb/tb_cpu_cu.sv
// tb/tb_cpu_cu.sv - directed self-checking bench for cpu_cu
module tb_cpu_cu;

  logic        clk;
  logic        reset;
  logic [15:0] ir;
  logic        n_in, z_in, c_in;
  logic        adr_sel, s_sel, pc_ld, pc_inc, reg_w_en, ir_ld, mem_rd, mem_wr;
  logic [2:0]  status;
  logic [2:0]  state;
  logic        halted;
  logic [7:0]  ctl;

  int checks = 0;
  int fails  = 0;

  // {adr_sel, s_sel, pc_ld, pc_inc, reg_w_en, ir_ld, mem_rd, mem_wr}
  localparam logic [7:0] CTL_FETCH  = 8'b0001_0110;
  localparam logic [7:0] CTL_NONE   = 8'b0000_0000;
  localparam logic [7:0] CTL_ALU    = 8'b0000_1000;
  localparam logic [7:0] CTL_LOAD   = 8'b1100_1010;
  localparam logic [7:0] CTL_STORE  = 8'b1000_0001;
  localparam logic [7:0] CTL_BR_TK  = 8'b0010_0000;

  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_ALU = 3'd2, S_LOAD = 3'd3;
  localparam logic [2:0] S_STORE = 3'd4, S_BRANCH = 3'd5, S_HALT = 3'd6;

  assign ctl = {adr_sel, s_sel, pc_ld, pc_inc, reg_w_en, ir_ld, mem_rd, mem_wr};

  cpu_cu dut (
    .clk      (clk),
    .reset    (reset),
    .ir       (ir),
    .n_in     (n_in),
    .z_in     (z_in),
    .c_in     (c_in),
    .adr_sel  (adr_sel),
    .s_sel    (s_sel),
    .pc_ld    (pc_ld),
    .pc_inc   (pc_inc),
    .reg_w_en (reg_w_en),
    .ir_ld    (ir_ld),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .status   (status),
    .state    (state),
    .halted   (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  // From a FETCH cycle: load ir, advance through DECODE into the execute cycle.
  task automatic issue(input logic [15:0] v);
    ir = v;
    step();
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ir = 16'h0000;
    {n_in, z_in, c_in} = 3'b000;
    step();
    step();
    checks++; if (state !== S_FETCH) begin fails++; $display("FAIL reset_state: got %0d expected %0d", state, S_FETCH); end
    checks++; if (status !== 3'b000) begin fails++; $display("FAIL reset_status: got %b expected 000", status); end
    checks++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted: got %b expected 0", halted); end
    checks++; if (ctl !== CTL_FETCH) begin fails++; $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_FETCH); end
    reset = 1'b1;
    #1;
    checks++; if (ctl !== CTL_FETCH || state !== S_FETCH) begin fails++; $display("FAIL cycle0_fetch: got ctl %b state %0d expected ctl %b state 0", ctl, state, CTL_FETCH); end
    step();
    checks++; if (ctl !== CTL_NONE || state !== S_DECODE) begin fails++; $display("FAIL cycle1_decode: got ctl %b state %0d expected ctl 0 state 1", ctl, state); end
    step();
    checks++; if (ctl !== CTL_ALU || state !== S_ALU) begin fails++; $display("FAIL cycle2_alu: got ctl %b state %0d expected ctl %b state 2", ctl, state, CTL_ALU); end
    step();
  endtask

  task automatic test_alu();
    issue(16'h1A53);
    {n_in, z_in, c_in} = 3'b011;
    checks++; if (status !== 3'b000) begin fails++; $display("FAIL alu_status_before_edge: got %b expected 000", status); end
    step();
    checks++; if (status !== 3'b011) begin fails++; $display("FAIL alu_status: got %b expected 011", status); end
    checks++; if (state !== S_FETCH) begin fails++; $display("FAIL alu_next_fetch: got %0d expected 0", state); end
  endtask

  task automatic test_load_store();
    issue(16'hC0C8);
    {n_in, z_in, c_in} = 3'b100;
    checks++; if (ctl !== CTL_LOAD || state !== S_LOAD) begin fails++; $display("FAIL load_ctl: got ctl %b state %0d expected ctl %b state 3", ctl, state, CTL_LOAD); end
    step();
    checks++; if (status !== 3'b011) begin fails++; $display("FAIL load_status: got %b expected 011", status); end
    issue(16'hD0C8);
    checks++; if (ctl !== CTL_STORE || state !== S_STORE) begin fails++; $display("FAIL store_ctl: got ctl %b state %0d expected ctl %b state 4", ctl, state, CTL_STORE); end
    step();
    checks++; if (status !== 3'b011 || state !== S_FETCH) begin fails++; $display("FAIL store_after: got status %b state %0d expected status 011 state 0", status, state); end
  endtask

  task automatic test_branch();
    issue(16'hE200);
    checks++; if (ctl !== CTL_BR_TK || state !== S_BRANCH) begin fails++; $display("FAIL br_z_taken: got ctl %b state %0d expected ctl %b state 5", ctl, state, CTL_BR_TK); end
    step();
    issue(16'h0000);
    {n_in, z_in, c_in} = 3'b000;
    step();
    issue(16'hE200);
    checks++; if (ctl !== CTL_NONE) begin fails++; $display("FAIL br_z_not_taken: got ctl %b expected 0", ctl); end
    step();
    issue(16'hE400);
    checks++; if (pc_ld !== 1'b1) begin fails++; $display("FAIL br_nz_taken: got pc_ld %b expected 1", pc_ld); end
    step();
    issue(16'hE000);
    checks++; if (ctl !== CTL_BR_TK) begin fails++; $display("FAIL br_always: got ctl %b expected %b", ctl, CTL_BR_TK); end
    step();
    issue(16'hEE00);
    checks++; if (ctl !== CTL_NONE || state !== S_BRANCH) begin fails++; $display("FAIL br_never: got ctl %b state %0d expected ctl 0 state 5", ctl, state); end
    step();
    issue(16'h0000);
    {n_in, z_in, c_in} = 3'b101;
    step();
    issue(16'hEA00);
    checks++; if (pc_ld !== 1'b1) begin fails++; $display("FAIL br_c_after_alu: got pc_ld %b expected 1", pc_ld); end
    step();
    issue(16'hE800);
    checks++; if (pc_ld !== 1'b0) begin fails++; $display("FAIL br_nn_not_taken: got pc_ld %b expected 0", pc_ld); end
    step();
  endtask

  task automatic test_halt();
    int bad = 0;
    ir = 16'hF000;
    checks++; if (halted !== 1'b0 || state !== S_FETCH) begin fails++; $display("FAIL halt_cycle0: got halted %b state %0d expected 0 / 0", halted, state); end
    step();
    checks++; if (halted !== 1'b0 || state !== S_DECODE) begin fails++; $display("FAIL halt_cycle1: got halted %b state %0d expected 0 / 1", halted, state); end
    step();
    for (int i = 0; i < 20; i++) begin
      if (halted !== 1'b1 || ctl !== CTL_NONE || state !== S_HALT) bad++;
      step();
    end
    checks++; if (bad !== 0) begin fails++; $display("FAIL halt_hold: got %0d bad cycles expected 0", bad); end
    reset = 1'b0;
    #1;
    checks++; if (state !== S_FETCH || halted !== 1'b0 || ctl !== CTL_FETCH) begin fails++; $display("FAIL halt_reset: got state %0d halted %b ctl %b expected 0 / 0 / %b", state, halted, ctl, CTL_FETCH); end
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset_mid_store();
    do_reset();
    {n_in, z_in, c_in} = 3'b101;
    issue(16'h0000);
    step();
    checks++; if (status !== 3'b101) begin fails++; $display("FAIL mid_store_setup: got status %b expected 101", status); end
    issue(16'hD0C8);
    checks++; if (mem_wr !== 1'b1) begin fails++; $display("FAIL mid_store_wr: got mem_wr %b expected 1", mem_wr); end
    #2 reset = 1'b0;
    #1;
    checks++; if (mem_wr !== 1'b0 || reg_w_en !== 1'b0 || state !== S_FETCH) begin fails++; $display("FAIL mid_store_abort: got mem_wr %b reg_w_en %b state %0d expected 0 / 0 / 0", mem_wr, reg_w_en, state); end
    checks++; if (status !== 3'b000) begin fails++; $display("FAIL mid_store_status: got %b expected 000", status); end
    #1 reset = 1'b1;
    #1;
    checks++; if (ctl !== CTL_FETCH) begin fails++; $display("FAIL mid_store_fetch: got ctl %b expected %b", ctl, CTL_FETCH); end
    step();
    checks++; if (state !== S_DECODE) begin fails++; $display("FAIL mid_store_decode: got %0d expected 1", state); end
  endtask

  initial begin
    reset = 1'b0;
    ir = 16'h0000;
    {n_in, z_in, c_in} = 3'b000;
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_halt();
    test_reset_mid_store();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
